hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Stall/flush controller for the non-forwarding 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Drives the PC register's stall input and the IF/ID, ID/EX pipeline-register controls.
//  A per-register countdown scoreboard stalls RAW consumers in ID until the producer's
//  writeback completes. EX branch/jump redirects flush the wrong-path instructions.
// PARAMETERS
//  NREG   32  architectural registers; index 0 (x0) is hardwired and never busy
//  WB_LAT 3   cycles from ID->EX issue until the regfile write is visible
//  CNT_W  32  width of the stall performance counter
// PORTS
//  i_clk          in  1      clock; all state updates on posedge
//  i_rst          in  1      reset, synchronous, active-high
//  i_id_valid     in  1      ID stage holds a valid instruction
//  i_id_rs1       in  5      ID source register 1
//  i_id_rs2       in  5      ID source register 2
//  i_id_rs1_used  in  1      instruction reads rs1
//  i_id_rs2_used  in  1      instruction reads rs2
//  i_id_rd        in  5      ID destination register
//  i_id_rd_wr     in  1      instruction writes rd
//  i_ex_redirect  in  1      EX resolved taken branch/jump; PC mux loads target
//  o_stall_pc     out 1      hold PC (feeds the PC register's stall input)
//  o_stall_ifid   out 1      hold IF/ID register
//  o_flush_ifid   out 1      clear IF/ID register to bubble
//  o_flush_idex   out 1      load bubble into ID/EX
//  o_busy_map     out NREG   bit r = 1 while register r has a pending write
//  o_stall_cnt    out CNT_W  count of RAW stall cycles since reset, saturating
// BEHAVIOUR
//  - State: cnt[r], width clog2(WB_LAT+1), for r=1..NREG-1; stall counter. cnt[0] is constant 0.
//  - Reset: i_rst=1 at a posedge clears every cnt and o_stall_cnt. While i_rst=1:
//    o_stall_pc=0, o_stall_ifid=0, o_flush_ifid=1, o_flush_idex=1. o_busy_map=0 after reset.
//  - hit(rs) = i_id_valid & rs_used & (rs!=0) & (cnt[rs] > THR); THR=0 (see CONFIGURATION).
//  - raw = hit(rs1) | hit(rs2). All control outputs are combinational from the current state
//    and inputs, with zero added latency.
//  - Priority when i_ex_redirect=1: o_flush_ifid=1, o_flush_idex=1, o_stall_pc=0,
//    o_stall_ifid=0. raw is ignored and no issue occurs.
//  - Otherwise when raw=1: o_stall_pc=1, o_stall_ifid=1, o_flush_idex=1, o_flush_ifid=0.
//    o_stall_cnt increments and saturates at all-ones.
//  - Otherwise all control outputs are 0.
//  - issue = i_id_valid & ~raw & ~i_ex_redirect & ~i_rst.
//  - Per posedge, each cnt[r]!=0 decrements by 1.
//    If issue & i_id_rd_wr & i_id_rd!=0, cnt[i_id_rd] loads WB_LAT. This overrides the
//    decrement (WAW to a still-busy rd restarts the count).
//  - Same-cycle issue and read of the same register: the read checks the old cnt.
//  - o_busy_map[r] = (cnt[r] != 0).
//  - A flushed instruction never sets the scoreboard. Instructions already in EX/MEM/WB
//    keep counting down through a redirect.
// CONFIGURATION
//  RF_BYPASS_EN defined: the regfile forwards its write port to reads in the same cycle.
//    THR=1, so a consumer is released in the cycle the producer is in WB.
//    Producer-to-consumer RAW stall = WB_LAT-1 cycles.
//  Not defined: THR=0. Consumer waits until the write has completed.
//    RAW stall = WB_LAT cycles.
// TESTING
//  1. Reset: i_rst=1 for 2 cycles, ID valid, rd=5, rd_wr=1 -> flushes=1, stalls=0.
//     After release, busy_map=0 and stall_cnt=0.
//  2. RAW: issue rd=5 wr; next cycle ID rs1=5 used -> stall_pc/stall_ifid/flush_idex=1
//     for 3 cycles, then 0. stall_cnt=3. With RF_BYPASS_EN: 2 cycles, stall_cnt=2.
//  3. x0: issue rd=0 wr, then read rs1=0 -> busy_map=0, no stall.
//  4. Independent: issue rd=5; next ID rs1=6, rs2=7 -> no stall; busy_map[5]=1 for 3 cycles.
//  5. Redirect during RAW stall: i_ex_redirect=1 -> stall_pc=0, flush_ifid=1, flush_idex=1.
//     ID rd=9 is not marked; busy_map[9] stays 0.
//  6. WAW: issue rd=5, then 1 cycle later issue rd=5 again -> busy_map[5] stays 1 for
//     3 cycles after the second issue.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//  Stall/flush controller for a non-forwarding 5-stage pipeline (IF/ID/EX/MEM/WB).
//  A per-register countdown scoreboard tracks pending writebacks. A RAW consumer
//  sitting in ID is held until its producer's write is visible. An EX redirect
//  flushes the wrong-path instructions in IF/ID and ID/EX.
//
//  Optional feature macro: RF_BYPASS_EN
//    Defined     : the regfile writes through to same-cycle reads, so a consumer
//                  is released while its producer is in WB (stall = WB_LAT-1).
//    Not defined : a consumer waits until the write has completed (stall = WB_LAT).
module hazard_stall_ctrl #(
    parameter int NREG   = 32,
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [4:0]        i_id_rd,
    input  logic              i_id_rd_wr,
    input  logic              i_ex_redirect,
    output logic              o_stall_pc,
    output logic              o_stall_ifid,
    output logic              o_flush_ifid,
    output logic              o_flush_idex,
    output logic [NREG-1:0]   o_busy_map,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // Width of one scoreboard countdown entry: must hold the value WB_LAT.
    localparam int CW = (WB_LAT > 0) ? $clog2(WB_LAT + 1) : 1;

    localparam logic [CW-1:0]    ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C     = CW'(32'd1);
    localparam logic [CW-1:0]    LAT_C     = CW'(WB_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(32'd1);

    // Release threshold: with a write-through regfile the consumer may read in
    // the same cycle as the producer's write, i.e. when one cycle remains.
`ifdef RF_BYPASS_EN
    localparam logic [CW-1:0] THR_C = CW'(32'd1);
`else
    localparam logic [CW-1:0] THR_C = CW'(32'd0);
`endif

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A source operand hits the scoreboard when it is really read, is not x0,
    // and its producer still needs more than THR cycles to become visible.
    function automatic logic hit_f(
        input logic          valid,
        input logic          used,
        input logic [4:0]    idx,
        input logic [CW-1:0] cnt_val
    );
        hit_f = valid & used & (idx != 5'd0) & (cnt_val > THR_C);
    endfunction

    // Saturating increment for the stall performance counter.
    function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX_C) begin
            sat_inc_f = val;
        end else begin
            sat_inc_f = val + CNT_ONE_C;
        end
    endfunction

    // One-step countdown: decrement toward zero, never wrap.
    function automatic logic [CW-1:0] dec_f(input logic [CW-1:0] val);
        if (val != ZERO_C) begin
            dec_f = val - ONE_C;
        end else begin
            dec_f = val;
        end
    endfunction

    // ------------------------------------------------------------------
    // State and internal signals
    // ------------------------------------------------------------------
    logic [CW-1:0]    cnt_r      [NREG];
    logic [CW-1:0]    cnt_nxt_s  [NREG];
    logic [NREG-1:0]  wr_dec_s;
    logic [NREG-1:0]  busy_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             hit1_s;
    logic             hit2_s;
    logic             raw_s;
    logic             issue_s;
    logic             issue_wr_s;
    logic             stall_inc_s;

    logic             stall_pc_s;
    logic             stall_ifid_s;
    logic             flush_ifid_s;
    logic             flush_idex_s;

    // ------------------------------------------------------------------
    // Hazard detection (reads the pre-update counts, so a same-cycle issue
    // to the register being read does not affect the current instruction)
    // ------------------------------------------------------------------
    assign hit1_s = hit_f(i_id_valid, i_id_rs1_used, i_id_rs1, cnt_r[i_id_rs1]);
    assign hit2_s = hit_f(i_id_valid, i_id_rs2_used, i_id_rs2, cnt_r[i_id_rs2]);
    assign raw_s  = hit1_s | hit2_s;

    // An instruction leaves ID only when it is not stalled, not being flushed
    // by a redirect and the pipeline is not in reset.
    assign issue_s     = i_id_valid & ~raw_s & ~i_ex_redirect & ~i_rst;
    assign issue_wr_s  = issue_s & i_id_rd_wr & (i_id_rd != 5'd0);
    assign stall_inc_s = raw_s & ~i_ex_redirect & ~i_rst;

    // Decode the issuing instruction's destination into a one-hot load vector.
    always_comb begin
        wr_dec_s = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            if (issue_wr_s && (i_id_rd == 5'(r))) begin
                wr_dec_s[r] = 1'b1;
            end else begin
                wr_dec_s[r] = 1'b0;
            end
        end
    end

    // Next scoreboard count: a fresh issue reloads WB_LAT (restarting on WAW),
    // otherwise pending entries count down; x0 stays at zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt_s[r] = ZERO_C;
        end
        for (int r = 1; r < NREG; r++) begin
            if (wr_dec_s[r]) begin
                cnt_nxt_s[r] = LAT_C;
            end else begin
                cnt_nxt_s[r] = dec_f(cnt_r[r]);
            end
        end
    end

    // Scoreboard registers: cleared by reset, otherwise take the next count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= ZERO_C;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

    // Stall performance counter: counts every cycle spent holding a RAW consumer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_inc_s) begin
            stall_cnt_r <= sat_inc_f(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Busy map: one bit per register with a write still outstanding.
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            busy_s[r] = (cnt_r[r] != ZERO_C);
        end
    end

    // Pipeline control: reset and redirect flush both registers, a RAW hazard
    // freezes PC and IF/ID while inserting a bubble into ID/EX.
    always_comb begin
        stall_pc_s   = 1'b0;
        stall_ifid_s = 1'b0;
        flush_ifid_s = 1'b0;
        flush_idex_s = 1'b0;
        if (i_rst) begin
            flush_ifid_s = 1'b1;
            flush_idex_s = 1'b1;
        end else if (i_ex_redirect) begin
            flush_ifid_s = 1'b1;
            flush_idex_s = 1'b1;
        end else if (raw_s) begin
            stall_pc_s   = 1'b1;
            stall_ifid_s = 1'b1;
            flush_idex_s = 1'b1;
        end else begin
            stall_pc_s   = 1'b0;
            stall_ifid_s = 1'b0;
            flush_ifid_s = 1'b0;
            flush_idex_s = 1'b0;
        end
    end

    assign o_stall_pc   = stall_pc_s;
    assign o_stall_ifid = stall_ifid_s;
    assign o_flush_ifid = flush_ifid_s;
    assign o_flush_idex = flush_idex_s;
    assign o_busy_map   = busy_s;
    assign o_stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: table of per-cycle vectors with hand-computed
// expected control outputs, busy map and stall count, plus a bounded RAW sequence.
module tb_hazard_stall_ctrl;

`ifdef RF_BYPASS_EN
    localparam int S = 2;
`else
    localparam int S = 3;
`endif

    // {stall_pc, stall_ifid, flush_ifid, flush_idex}
    localparam logic [3:0] RUN   = 4'b0000;
    localparam logic [3:0] STALL = 4'b1101;
    localparam logic [3:0] FLUSH = 4'b0011;

    logic        clk = 1'b0;
    logic        rst, id_valid, rs1_used, rs2_used, rd_wr, ex_redirect;
    logic [4:0]  rs1, rs2, rd;
    logic        stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic [31:0] busy_map;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_id_valid    (id_valid),
        .i_id_rs1      (rs1),
        .i_id_rs2      (rs2),
        .i_id_rs1_used (rs1_used),
        .i_id_rs2_used (rs2_used),
        .i_id_rd       (rd),
        .i_id_rd_wr    (rd_wr),
        .i_ex_redirect (ex_redirect),
        .o_stall_pc    (stall_pc),
        .o_stall_ifid  (stall_ifid),
        .o_flush_ifid  (flush_ifid),
        .o_flush_idex  (flush_idex),
        .o_busy_map    (busy_map),
        .o_stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        redir;
        logic [3:0]  ctrl;
        logic [31:0] busy;
        logic [31:0] scnt;
        bit          chk;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic v, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub, input logic [4:0] d, input logic w,
                       input logic x, input logic [3:0] ctrl, input logic [31:0] busy,
                       input int scnt, input bit chk);
        vec_t e;
        e.rst = r; e.valid = v; e.rs1 = a; e.u1 = ua; e.rs2 = b; e.u2 = ub;
        e.rd = d; e.wr = w; e.redir = x; e.ctrl = ctrl; e.busy = busy;
        e.scnt = 32'(scnt); e.chk = chk;
        tbl.push_back(e);
    endtask

    task automatic idle(input logic [31:0] busy, input int scnt);
        add(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, RUN, busy, scnt, 1'b1);
    endtask

    task automatic apply(input vec_t e);
        rst = e.rst; id_valid = e.valid; rs1 = e.rs1; rs1_used = e.u1;
        rs2 = e.rs2; rs2_used = e.u2; rd = e.rd; rd_wr = e.wr; ex_redirect = e.redir;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [31:0] b5, b8, b10, b3;
        vec_t        h;
        int          n;
        logic        released;
        b3 = 32'd1 << 3; b5 = 32'd1 << 5; b8 = 32'd1 << 8; b10 = 32'd1 << 10;

        // Reset held two cycles with a valid writer in ID: flushes, no stall, no marking.
        add(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, FLUSH, 32'd0, 0, 1'b0);
        add(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, FLUSH, 32'd0, 0, 1'b1);
        idle(32'd0, 0);

        // RAW: producer rd=5, consumer reads rs1=5 (and writes rd=10 once released).
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUN, 32'd0, 0, 1'b1);
        for (int k = 0; k < S; k++)
            add(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, STALL, b5, k, 1'b1);
        add(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, RUN,
            (S == 3) ? 32'd0 : b5, S, 1'b1);
        for (int k = 0; k < 3; k++) idle(b10, S);

        // x0 is never busy and never stalls.
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, RUN, 32'd0, S, 1'b1);
        add(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, RUN, 32'd0, S, 1'b1);

        // Independent consumer: no stall, rd=5 busy for three observations.
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUN, 32'd0, S, 1'b1);
        add(1'b0, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, RUN, b5, S, 1'b1);
        idle(b5, S);
        idle(b5, S);

        // Redirect during a RAW stall on rs2: flush wins, rd=9 never marked,
        // rd=5 keeps counting down through the redirect.
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUN, 32'd0, S, 1'b1);
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, STALL, b5, S, 1'b1);
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b1, FLUSH, b5, S + 1, 1'b1);
        idle(b5, S + 1);
        idle(32'd0, S + 1);

        // WAW: second write to rd=5 restarts its count.
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUN, 32'd0, S + 1, 1'b1);
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUN, b5, S + 1, 1'b1);
        for (int k = 0; k < 3; k++) idle(b5, S + 1);
        idle(32'd0, S + 1);

        // Redirect with an otherwise issuable writer: no issue happens.
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, FLUSH, 32'd0, S + 1, 1'b1);
        idle(32'd0, S + 1);

        // Reset in the middle of a pending write clears busy map and stall count.
        add(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, RUN, 32'd0, S + 1, 1'b1);
        add(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, FLUSH, b3, S + 1, 1'b1);
        idle(32'd0, 0);

        // Same-cycle issue and read of rd=8: reads the old (idle) count.
        add(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, RUN, 32'd0, 0, 1'b1);
        for (int k = 0; k < 3; k++) idle(b8, 0);
        idle(32'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            check("ctrl", i, {28'd0, stall_pc, stall_ifid, flush_ifid, flush_idex},
                  {28'd0, tbl[i].ctrl});
            if (tbl[i].chk) begin
                check("busy_map", i, busy_map, tbl[i].busy);
                check("stall_cnt", i, stall_cnt, tbl[i].scnt);
            end
            @(posedge clk);
            #1;
        end

        // Bounded RAW sequence on rs2: measure stall length directly.
        h = tbl[0];
        h.rst = 1'b0; h.valid = 1'b1; h.u1 = 1'b0; h.u2 = 1'b0; h.rd = 5'd12;
        h.wr = 1'b1; h.redir = 1'b0;
        apply(h);
        @(posedge clk);
        #1;
        h.rs2 = 5'd12; h.u2 = 1'b1; h.rd = 5'd0; h.wr = 1'b0;
        apply(h);
        n = 0;
        released = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!stall_pc) begin
                released = 1'b1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
        end
        check("raw_release", 0, {31'd0, released}, 32'd1);
        check("raw_length", 0, 32'(n), 32'(S));
        check("raw_stall_cnt", 0, stall_cnt, 32'(S));

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
